// File: rtl/reg_file_bcd.sv
// reg_file_bcd: 2-read/1-write register file; every write also starts a shift-add-3
// binary-to-BCD conversion of WriteData. Define RF_BYPASS_EN for write-first read forwarding.
module reg_file_bcd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     ReadReg1,
  input  logic [ADDR_W-1:0]     ReadReg2,
  input  logic [ADDR_W-1:0]     WriteReg,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic                  RegWrite,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [4*DIGITS-1:0]   BcdDigits,
  output logic                  BcdValid,
  output logic                  BcdBusy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcdAdj;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (RegWrite) begin
      mem_q[WriteReg] <= WriteData;
    end
  end

`ifdef RF_BYPASS_EN
  assign ReadData1 = (RegWrite && (WriteReg == ReadReg1)) ? WriteData : mem_q[ReadReg1];
  assign ReadData2 = (RegWrite && (WriteReg == ReadReg2)) ? WriteData : mem_q[ReadReg2];
`else
  assign ReadData1 = mem_q[ReadReg1];
  assign ReadData2 = mem_q[ReadReg2];
`endif

  // Digit correction applied before each shift so no digit overflows past 9.
  always_comb begin
    bcdAdj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcdAdj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = 1'b0;
    if (state_q == SHIFT) begin
      {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        digits_d = bcd_d;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    end
    // A new write always wins: it restarts the converter even on the completion edge.
    if (RegWrite) begin
      bin_d   = WriteData;
      bcd_d   = '0;
      cnt_d   = CNT_W'(DATA_W);
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
    end
  end

  assign BcdDigits = digits_q;
  assign BcdValid  = valid_q;
  assign BcdBusy   = (state_q == SHIFT);

endmodule

// File: tb/tb_reg_file_bcd.sv
// Self-checking bench for reg_file_bcd: directed scenarios followed by random traffic,
// all compared against a value-level model (decimal arithmetic, remaining-clock counter).
`timescale 1ns/1ps
module tb_reg_file_bcd;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DIGITS = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0;
  logic [DATA_W-1:0] WriteData = '0;
  logic              RegWrite = 1'b0;
  logic [DATA_W-1:0] ReadData1, ReadData2;
  logic [11:0]       BcdDigits;
  logic              BcdValid, BcdBusy;

  int checkCount = 0;
  int passCount  = 0;

  int          modelRegs [DEPTH];
  bit          modelBusy;
  int          modelLeft;
  int          modelValue;
  logic [11:0] modelDigits;
  logic        modelValid;

  reg_file_bcd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .BcdDigits(BcdDigits), .BcdValid(BcdValid), .BcdBusy(BcdBusy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] toBcd(int v);
    logic [11:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] expRead(logic [ADDR_W-1:0] a);
`ifdef RF_BYPASS_EN
    if (RegWrite && (WriteReg == a)) return WriteData;
`endif
    return DATA_W'(modelRegs[a]);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " ReadData1"}, 32'(ReadData1), 32'(expRead(ReadReg1)));
    checkVal({tag, " ReadData2"}, 32'(ReadData2), 32'(expRead(ReadReg2)));
    checkVal({tag, " BcdDigits"}, 32'(BcdDigits), 32'(modelDigits));
    checkVal({tag, " BcdValid"},  32'(BcdValid),  32'(modelValid));
    checkVal({tag, " BcdBusy"},   32'(BcdBusy),   32'(modelBusy));
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) modelRegs[i] = 0;
    modelBusy   = 1'b0;
    modelLeft   = 0;
    modelValue  = 0;
    modelDigits = '0;
    modelValid  = 1'b0;
  endtask

  // One rising edge worth of behaviour: finish the pending conversion, then accept a write.
  task automatic modelEdge();
    modelValid = 1'b0;
    if (modelBusy) begin
      modelLeft--;
      if (modelLeft == 0) begin
        modelDigits = toBcd(modelValue);
        modelValid  = 1'b1;
        modelBusy   = 1'b0;
      end
    end
    if (RegWrite) begin
      modelRegs[WriteReg] = int'(WriteData);
      modelValue = int'(WriteData);
      modelLeft  = DATA_W;
      modelBusy  = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string tag, input bit we, input logic [ADDR_W-1:0] wr,
                               input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r1,
                               input logic [ADDR_W-1:0] r2);
    @(negedge clk);
    RegWrite  = we;
    WriteReg  = wr;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
    #1 checkOutput(tag);
    @(posedge clk);
    modelEdge();
  endtask

  task automatic idleSteps(input string tag, input int n, input logic [ADDR_W-1:0] r1,
                           input logic [ADDR_W-1:0] r2);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, '0, '0, r1, r2);
  endtask

  initial begin
    modelReset();

    // Reset held across edges, then released between edges.
    @(negedge clk);
    #1 checkOutput("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 255 into reg 3, read on both ports, conversion result after 8 clocks.
    applyStimulus("t2 write", 1'b1, 2'd3, 8'd255, 2'd3, 2'd3);
    applyStimulus("t2 read", 1'b0, 2'd0, 8'd0, 2'd3, 2'd3);
    checkVal("t2 ReadData1 const", 32'(ReadData1), 32'd255);
    checkVal("t2 ReadData2 const", 32'(ReadData2), 32'd255);
    idleSteps("t2 wait", 6, 2'd3, 2'd0);
    applyStimulus("t2 last", 1'b0, 2'd0, 8'd0, 2'd3, 2'd0);
    #1;
    checkVal("t2 valid const", 32'(BcdValid), 32'd1);
    checkVal("t2 digits const", 32'(BcdDigits), 32'h255);
    applyStimulus("t2 after", 1'b0, 2'd0, 8'd0, 2'd1, 2'd2);

    // 93 superseded by 7 on the 4th clock of its conversion.
    applyStimulus("t3 write93", 1'b1, 2'd1, 8'd93, 2'd1, 2'd2);
    idleSteps("t3 shift", 3, 2'd1, 2'd2);
    applyStimulus("t3 write7", 1'b1, 2'd2, 8'd7, 2'd1, 2'd2);
    idleSteps("t3 wait", 7, 2'd1, 2'd2);
    #1;
    checkVal("t3 no early valid", 32'(BcdValid), 32'd0);
    applyStimulus("t3 last", 1'b0, 2'd0, 8'd0, 2'd1, 2'd2);
    #1;
    checkVal("t3 valid const", 32'(BcdValid), 32'd1);
    checkVal("t3 digits const", 32'(BcdDigits), 32'h007);

    // Same-cycle write and read of reg 0 (forwarding depends on RF_BYPASS_EN).
    applyStimulus("t4 write40", 1'b1, 2'd0, 8'd40, 2'd0, 2'd3);
    idleSteps("t4 wait", 9, 2'd0, 2'd1);

    // Async reset in the middle of converting 128.
    applyStimulus("t5 write128", 1'b1, 2'd2, 8'd128, 2'd2, 2'd3);
    idleSteps("t5 shift", 3, 2'd2, 2'd3);
    @(negedge clk);
    RegWrite = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("t5 busy cleared", 32'(BcdBusy), 32'd0);
    checkVal("t5 digits cleared", 32'(BcdDigits), 32'h000);
    checkVal("t5 reg cleared", 32'(ReadData1), 32'd0);
    checkOutput("t5 in reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleSteps("t5 no pulse", 10, 2'd2, 2'd3);

    // Write of 10 exactly on the completion edge of 99.
    applyStimulus("t6 write99", 1'b1, 2'd2, 8'd99, 2'd2, 2'd1);
    idleSteps("t6 shift", 7, 2'd2, 2'd1);
    applyStimulus("t6 write10", 1'b1, 2'd1, 8'd10, 2'd2, 2'd1);
    #1;
    checkVal("t6 valid const", 32'(BcdValid), 32'd1);
    checkVal("t6 digits const", 32'(BcdDigits), 32'h099);
    checkVal("t6 busy const", 32'(BcdBusy), 32'd1);
    idleSteps("t6 wait", 7, 2'd1, 2'd2);
    applyStimulus("t6 last", 1'b0, 2'd0, 8'd0, 2'd1, 2'd2);
    #1;
    checkVal("t6 valid2 const", 32'(BcdValid), 32'd1);
    checkVal("t6 digits2 const", 32'(BcdDigits), 32'h010);

    // Random traffic; sparse writes let most conversions complete, some get restarted.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 6) == 0), 2'($urandom), 8'($urandom),
                    2'($urandom), 2'($urandom));
    end
    idleSteps("drain", 10, 2'd0, 2'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
